ldl_rr_req_queue: RTL
=====================

Name: ldl_rr_req_queue

Overview:
- Requester-side companion to the round-robin priority arbiter (LDL_rr_pri_v1 family).
- Queues per-lane work items, each tagged with a class of service, and presents them as req/cos vectors matching the arbiter's req/icos inputs.
- Consumes the arbiter's one-hot ack to retire the head item of the granted lane.
- One instance sits in front of each arbiter; REQ_WIDTH lanes with independent FIFOs.

Parameters:
- BIN_WIDTH, 3: lane index width.
- REQ_WIDTH, 1 << BIN_WIDTH: number of lanes; derived, do not override.
- COS_WIDTH, 2: class-of-service width.
- DEPTH_WIDTH, 2: per-lane FIFO depth = 1 << DEPTH_WIDTH entries.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous reset, active-high.
- push  input  REQ_WIDTH  per-lane enqueue strobe.
- push_cos  input  REQ_WIDTH x COS_WIDTH  per-lane cos of the pushed item.
- full  output  REQ_WIDTH  per-lane FIFO full, registered.
- level  output  REQ_WIDTH x (DEPTH_WIDTH+1)  per-lane occupancy, registered.
- req  output  REQ_WIDTH  lane non-empty; drives arbiter req.
- cos  output  REQ_WIDTH x COS_WIDTH  head-entry cos per lane; drives arbiter icos.
- ack  input  REQ_WIDTH  one-hot retire strobe from arbiter.
- clr_err  input  1  synchronous clear of the sticky error flags.
- err_ovf  output  1  sticky: a push was attempted to a full lane.
- err_unf  output  1  sticky: ack arrived on an empty lane, or ack was not one-hot.

Behaviour:
- Reset values: all levels 0, req 0, full 0, cos 0, err_ovf 0, err_unf 0. FIFO storage is not reset, but cos is forced to 0 when the lane is empty.
- Reset mid-operation discards every queued item. req drops asynchronously with rst.
- Per-lane state: write pointer, read pointer (DEPTH_WIDTH bits, wrap modulo depth) and a count (DEPTH_WIDTH+1 bits, range 0..depth).
- Outputs derive only from registers: req[i] = count != 0; full[i] = count == depth; cos[i] = mem[i][rd_ptr]. There is no combinational path from ack or push to any output.
- Push on lane i, not full: write push_cos[i] at wr_ptr, increment wr_ptr. Visible on req/level at the next edge, so latency is 1 cycle.
- Push on lane i, full: item dropped, no state change, err_ovf set.
- This rule holds even if ack[i] is asserted in the same cycle, so full acceptance never depends on ack.
- Ack on lane i, non-empty: increment rd_ptr. The new head cos (or req = 0) appears after the next edge.
- Ack on lane i, empty: ignored, err_unf set.
- Simultaneous accepted push and ack on the same non-empty lane: count unchanged and both pointers advance. If count was 1, req stays 1 and cos shows the pushed item next cycle.
- Push and ack on an empty lane in the same cycle: push accepted, ack flagged as underflow, count becomes 1.
- Lanes operate independently; any number of lanes may push in the same cycle.
- More than one ack bit set: no lane is retired in that cycle, err_unf is set.
- Errors are sticky until clr_err. If clr_err and a new error event occur in the same cycle, the flag stays set.
- Count arithmetic: count_next = count + push_acc - ack_acc, computed at DEPTH_WIDTH+1 bits. It cannot exceed depth or go below 0 by construction.

Decomposition:
- Package ldl_rr_pkg:
  - localparams REQ_WIDTH from BIN_WIDTH.
  - typedef cos_t (logic [COS_WIDTH-1:0]), shared with LDL_rr_pri_v1.
  - typedef lvl_t.
- Sub-module ldl_rr_lane_fifo: single lane holding storage, pointers and count. It outputs nonempty, full, head, level, ovf_evt and unf_evt.
- The top instantiates REQ_WIDTH lanes in a generate loop and adds the one-hot check and the sticky error registers.

Test Plan:
- Reset then idle: req=0, cos=0, level=0, full=0 and err flags 0 for 10 cycles. Assert rst mid-queue: req drops immediately, level=0 after release.
- Push lane 2 with cos 3, then lane 2 with cos 1: the next cycle gives req=8'h04, cos[2]=3, level[2]=1, then level 2. ack=8'h04: cos[2]=1. A second ack: req=0, cos[2]=0.
- Push lane 5 four times (cos 0,1,2,3): full[5]=1, level[5]=4. A fifth push: err_ovf=1, level stays 4. Four acks drain the items in order 0,1,2,3. clr_err: err_ovf=0.
- Lane 0 at level 1 with simultaneous push (cos 2) and ack=8'h01: level stays 1, req[0]=1, cos[0]=2. Repeat at full with push+ack: push dropped, err_ovf=1, level 3.
- ack=8'h10 with lane 4 empty: err_unf=1, no level change. ack=8'h03 with lanes 0 and 1 each holding one item: err_unf=1, both levels stay 1.
- Drive the arbiter TB sequence: push all 8 lanes with cos pattern {3,2,1,0,3,2,1,0} into LDL_rr_pri_v1 with ready=1. Each grant's ocos matches the retired head, and the queue empties after 8 grants with req=0.

Source files
------------

// File: rtl/ldl_rr_pkg.sv
// Shared widths and types for the round-robin requester queue and its arbiter.
// cos_t is the class-of-service type both sides of the req/icos interface agree on.
package ldl_rr_pkg;

  localparam int BIN_WIDTH   = 3;
  localparam int REQ_WIDTH   = 1 << BIN_WIDTH;
  localparam int COS_WIDTH   = 2;
  localparam int DEPTH_WIDTH = 2;
  localparam int DEPTH       = 1 << DEPTH_WIDTH;

  typedef logic [COS_WIDTH-1:0]   cos_t;
  typedef logic [DEPTH_WIDTH:0]   lvl_t;
  typedef logic [REQ_WIDTH-1:0]   lane_vec_t;

endpackage

// File: rtl/ldl_rr_lane_fifo.sv
// One lane of the requester queue: circular storage, pointers and occupancy count.
// All outputs are functions of registered state only; events are raw strobes for the top.
module ldl_rr_lane_fifo #(
  parameter int COS_WIDTH   = 2,
  parameter int DEPTH_WIDTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [COS_WIDTH-1:0]   push_cos,
  input  logic                   ack,
  input  logic                   ack_en,
  output logic                   nonempty,
  output logic                   full,
  output logic [COS_WIDTH-1:0]   head,
  output logic [DEPTH_WIDTH:0]   level,
  output logic                   ovf_evt,
  output logic                   unf_evt
);

  localparam int DEPTH = 1 << DEPTH_WIDTH;
  localparam logic [DEPTH_WIDTH:0] LVL_FULL = (DEPTH_WIDTH+1)'(DEPTH);

  logic [COS_WIDTH-1:0]   mem_q [DEPTH];
  logic [DEPTH_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_WIDTH:0]   count_q, count_d;
  logic                   push_acc, ack_acc;

  // NOTE: every variable assigned here gets a value on every path, so no latch is inferred.
  always_comb begin
    push_acc = push && (count_q != LVL_FULL);
    ack_acc  = ack && ack_en && (count_q != '0);
    wr_ptr_d = wr_ptr_q + DEPTH_WIDTH'(push_acc);
    rd_ptr_d = rd_ptr_q + DEPTH_WIDTH'(ack_acc);
    count_d  = count_q + (DEPTH_WIDTH+1)'(push_acc) - (DEPTH_WIDTH+1)'(ack_acc);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage has no reset; the empty-lane gating on head hides stale contents.
  always_ff @(posedge clk) begin
    if (push_acc) mem_q[wr_ptr_q] <= push_cos;
  end

  assign nonempty = (count_q != '0);
  assign full     = (count_q == LVL_FULL);
  assign level    = count_q;
  assign head     = nonempty ? mem_q[rd_ptr_q] : '0;
  assign ovf_evt  = push && full;
  assign unf_evt  = ack && !nonempty;

endmodule

// File: rtl/ldl_rr_req_queue.sv
// Per-lane work queues presenting req/cos to a round-robin priority arbiter and
// retiring the head of the lane named by the arbiter's one-hot ack.
module ldl_rr_req_queue #(
  parameter  int BIN_WIDTH   = ldl_rr_pkg::BIN_WIDTH,
  parameter  int COS_WIDTH   = ldl_rr_pkg::COS_WIDTH,
  parameter  int DEPTH_WIDTH = ldl_rr_pkg::DEPTH_WIDTH,
  localparam int REQ_WIDTH   = 1 << BIN_WIDTH
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [REQ_WIDTH-1:0]                  push,
  input  logic [REQ_WIDTH-1:0][COS_WIDTH-1:0]   push_cos,
  output logic [REQ_WIDTH-1:0]                  full,
  output logic [REQ_WIDTH-1:0][DEPTH_WIDTH:0]   level,
  output logic [REQ_WIDTH-1:0]                  req,
  output logic [REQ_WIDTH-1:0][COS_WIDTH-1:0]   cos,
  input  logic [REQ_WIDTH-1:0]                  ack,
  input  logic                                  clr_err,
  output logic                                  err_ovf,
  output logic                                  err_unf
);

  logic                 ack_onehot;
  logic                 ack_multi;
  logic [REQ_WIDTH-1:0] ovf_evt;
  logic [REQ_WIDTH-1:0] unf_evt;
  logic                 err_ovf_q, err_ovf_d;
  logic                 err_unf_q, err_unf_d;

  for (genvar i = 0; i < REQ_WIDTH; i++) begin : g_lane
    ldl_rr_lane_fifo #(
      .COS_WIDTH   (COS_WIDTH),
      .DEPTH_WIDTH (DEPTH_WIDTH)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .push     (push[i]),
      .push_cos (push_cos[i]),
      .ack      (ack[i]),
      .ack_en   (ack_onehot),
      .nonempty (req[i]),
      .full     (full[i]),
      .head     (cos[i]),
      .level    (level[i]),
      .ovf_evt  (ovf_evt[i]),
      .unf_evt  (unf_evt[i])
    );
  end

  // A malformed ack retires nothing, so a glitching arbiter cannot drop two items at once.
  always_comb begin
    ack_onehot = $onehot(ack);
    ack_multi  = (ack != '0) && !ack_onehot;
    err_ovf_d  = (err_ovf_q && !clr_err) || (|ovf_evt);
    err_unf_d  = (err_unf_q && !clr_err) || (|unf_evt) || ack_multi;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_ovf_q <= 1'b0;
      err_unf_q <= 1'b0;
    end else begin
      err_ovf_q <= err_ovf_d;
      err_unf_q <= err_unf_d;
    end
  end

  assign err_ovf = err_ovf_q;
  assign err_unf = err_unf_q;

endmodule
